// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/gnt/rvalid memory port between instruction fetch and
// the MEM stage. Define MEM_ARB_TIMEOUT_EN to add a response watchdog and sticky bus_err.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] PCF,
  output logic [31:0] RD_instr,
  output logic        if_ready,
  output logic        stall_if,
  input  logic        dm_req,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] RD_data,
  output logic        dm_ready,
  output logic        stall_dm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, DREQ, DRSP, IREQ, IRSP} state_t;
  state_t state;

  // A requester being retired this cycle (ready high) is not eligible for arbitration.
  logic dm_go;
  logic if_go;
  assign dm_go    = dm_req & ~dm_ready;
  assign if_go    = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;
  assign stall_if = if_req & ~if_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             in_rsp;
  logic             timeout;
  assign in_rsp  = (state == DRSP) || (state == IRSP);
  assign timeout = in_rsp && !mem_rvalid && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared on entry to a response state, counts cycles without rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (((state == DREQ) || (state == IREQ)) && mem_gnt) begin
      wd_cnt <= '0;
    end else if (in_rsp && !mem_rvalid && !timeout) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (timeout) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  // Arbitration FSM: one outstanding transaction, bus fields latched in IDLE only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      RD_instr  <= NOP;
      RD_data   <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_go) begin
            state     <= DREQ;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUResultM;
            mem_wdata <= WriteDataM;
            mem_be    <= MemWriteM ? byteEnable : 4'hF;
          end else if (if_go) begin
            state    <= IREQ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= PCF;
            mem_be   <= 4'hF;
          end
        end
        DREQ: begin
          if (mem_gnt) begin
            state   <= DRSP;
            mem_req <= 1'b0;
          end
        end
        IREQ: begin
          if (mem_gnt) begin
            state   <= IRSP;
            mem_req <= 1'b0;
          end
        end
        DRSP: begin
          if (mem_rvalid) begin
            state    <= IDLE;
            dm_ready <= 1'b1;
            if (!mem_we) RD_data <= mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timeout) begin
            state    <= IDLE;
            dm_ready <= 1'b1;
            if (!mem_we) RD_data <= '0;
          end
`endif
        end
        IRSP: begin
          if (mem_rvalid) begin
            state    <= IDLE;
            if_ready <= 1'b1;
            RD_instr <= mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timeout) begin
            state    <= IDLE;
            if_ready <= 1'b1;
            RD_instr <= NOP;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single external memory port between the fetch stage (instruction reads at PCF) and the memory stage (loads/stores at ALUResultM) of the 5-stage RV32I pipeline. It runs a 5-state FSM with a single outstanding transaction and a req/gnt/rvalid bus handshake. It holds the returned instruction and load data stable in registers. It produces per-requester stall signals that the hazard unit ORs into StallF/StallD/FlushE.

## Interface
- TIMEOUT_CYCLES, 64, watchdog limit in response states (used only with MEM_ARB_TIMEOUT_EN).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch wants the instruction at PCF.
- PCF  in  32  fetch address, word-aligned.
- RD_instr  out  32  fetched instruction, registered.
- if_ready  out  1  one-cycle pulse: RD_instr valid for current if_req.
- stall_if  out  1  if_req & ~if_ready (combinational).
- dm_req  in  1  MEM stage has a load or store.
- MemWriteM  in  1  1 = store, 0 = load.
- ALUResultM  in  32  data address.
- WriteDataM  in  32  store data.
- byteEnable  in  4  store byte lanes.
- RD_data  out  32  raw load word, registered.
- dm_ready  out  1  one-cycle pulse: data access complete.
- stall_dm  out  1  dm_req & ~dm_ready (combinational).
- mem_req  out  1  bus request, registered.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_be  out  4  bus byte enables (4'b1111 on reads).
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  response or write acknowledge.
- mem_rdata  in  32  read data.
- bus_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, DREQ, DRSP, IREQ, IRSP.
- IDLE:
  - dm_req → DREQ. Latch address, we, wdata and be; for loads force be = 4'b1111.
  - Else if_req → IREQ. Latch PCF; we = 0; be = 4'b1111.
  - Data has fixed priority over fetch, because the data access is the older instruction.
- A requester whose ready output is high in the current cycle is ignored for arbitration in that cycle. This prevents re-servicing a request the pipeline is retiring on this edge.
- DREQ/IREQ:
  - mem_req = 1 with all bus outputs stable.
  - Stay until mem_gnt = 1, then go to DRSP/IRSP.
- DRSP/IRSP:
  - mem_req = 0; wait for mem_rvalid.
  - On mem_rvalid, return to IDLE. The next cycle pulses dm_ready/if_ready.
  - Load: RD_data ← mem_rdata. Fetch: RD_instr ← mem_rdata.
  - Store: RD_data is unchanged.
- mem_rvalid in DREQ/IREQ/IDLE is ignored, so gnt and rvalid are never consumed in the same cycle.
- RD_instr and RD_data hold their value until the next completing transaction of the same kind.
- Bus outputs not in a REQ state hold their last latched values; only mem_req qualifies them.

## Timing
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_ready, dm_ready, bus_err = 0.
  - mem_addr, mem_wdata = 0; mem_be = 0.
  - RD_instr = 32'h0000_0013 (NOP); RD_data = 0.
- Best-case latency, request seen in IDLE at cycle 0:
  - cycle 1: mem_req = 1 with mem_gnt = 1.
  - cycle 2: mem_rvalid = 1.
  - cycle 3: ready pulse with data valid, giving 3 cycles total.
- Each extra gnt or rvalid wait cycle adds one cycle.
- Simultaneous if_req and dm_req in IDLE: data goes first. Fetch starts the cycle after dm_ready, provided if_req is still high.
- Reset mid-transaction: the FSM returns to IDLE immediately and the outstanding bus transaction is abandoned. The memory model is reset by the same signal.
- stall_if and stall_dm are combinational from the inputs and the registered ready signals. There is no path from a bus input to a stall output.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter, cleared on entry to DRSP/IRSP, increments each cycle there without mem_rvalid.
  - At TIMEOUT_CYCLES the FSM returns to IDLE and the normal ready pulse is issued.
  - Fetch timeout: RD_instr ← 32'h0000_0013. Load timeout: RD_data ← 0.
  - bus_err is set and stays set until reset.
  - A timeout in a REQ state is not detected.
- Not defined: no counter; bus_err is tied 0; TIMEOUT_CYCLES is unused.

## Test plan
- Fetch only, mem_gnt and mem_rvalid immediate, mem_rdata = 32'h00500093 → if_ready at cycle 3, RD_instr = 32'h00500093, stall_if high on cycles 0–2.
- if_req and dm_req (load, addr 0x100) both high in IDLE → first mem_req has addr 0x100 and mem_we = 0; the fetch mem_req appears after dm_ready.
- Store: addr 0x104, WriteDataM = 0xDEADBEEF, byteEnable = 4'b0011, mem_gnt delayed 2 cycles → mem_req, mem_we, mem_be = 0011 held stable for 3 cycles; RD_data unchanged.
- mem_rvalid pulsed during DREQ, then a real rvalid 4 cycles after gnt → the early pulse is ignored; dm_ready 1 cycle after the real rvalid.
- reset asserted while in IRSP → mem_req = 0 and all ready signals 0 immediately; RD_instr = 0x00000013; a new fetch after release completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, rvalid never returned on a load → dm_ready after 8 IRSP/DRSP cycles, RD_data = 0, bus_err = 1 and stays 1.
